// File: rtl/cl_mem_access_pkg.sv
// Shared types for the memory-access stage: FSM states, byte-lane constants
// and the decode-flag bundle that the decode stage also uses.
package cl_mem_access_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [1:0] byte_off_t;

  localparam logic [3:0] BE_WORD  = 4'b1111;
  localparam logic [3:0] BE_BYTE0 = 4'b0001;

  typedef struct packed {
    logic is_load;
    logic is_store;
    logic is_byte;
  } mem_flags_t;

  function automatic logic is_mem_op(input logic valid, input mem_flags_t flags);
    return valid & (flags.is_load | flags.is_store);
  endfunction

endpackage

// File: rtl/cl_mem_lane.sv
// Combinational byte-lane steering: byte enables and replicated write data
// for requests, byte extraction and zero-extension for load responses.
module cl_mem_lane
  import cl_mem_access_pkg::*;
(
  input  logic        is_byte,
  input  byte_off_t   offset,
  input  logic [31:0] store_data,
  input  logic [31:0] resp_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  always_comb begin
    be        = BE_WORD;
    wdata     = store_data;
    load_data = resp_data;
    if (is_byte) begin
      be    = BE_BYTE0 << offset;
      wdata = {4{store_data[7:0]}};
      case (offset)
        2'd0:    load_data = {24'b0, resp_data[7:0]};
        2'd1:    load_data = {24'b0, resp_data[15:8]};
        2'd2:    load_data = {24'b0, resp_data[23:16]};
        default: load_data = {24'b0, resp_data[31:24]};
      endcase
    end
  end

endmodule

// File: rtl/cl_mem_access.sv
// Memory-access stage controller: request/response handshake with data memory,
// stalling upstream until done. Define MEM_ALIGN_CHECK_EN to trap misaligned word ops.
module cl_mem_access
  import cl_mem_access_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int STALL_CNT_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_i,
  input  logic                       is_load_op_i,
  input  logic                       is_store_op_i,
  input  logic                       is_byte_op_i,
  input  logic [ADDR_WIDTH-1:0]      addr_i,
  input  logic [31:0]                store_data_i,
  output logic                       stall_o,
  output logic                       load_valid_o,
  output logic [31:0]                load_data_o,
  output logic                       mem_req_valid_o,
  input  logic                       mem_req_ready_i,
  output logic                       mem_we_o,
  output logic [ADDR_WIDTH-1:0]      mem_addr_o,
  output logic [31:0]                mem_wdata_o,
  output logic [3:0]                 mem_be_o,
  input  logic                       mem_resp_valid_i,
  input  logic [31:0]                mem_resp_data_i,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                       misaligned_o,
`endif
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles_o
);

  state_t     state;
  mem_flags_t flags;
  logic       mem_op;
  logic       op_load_q;
  logic       op_byte_q;
  byte_off_t  op_off_q;
  logic       lane_byte;
  byte_off_t  lane_off;
  logic [3:0] lane_be;
  logic [31:0] lane_wdata;
  logic [31:0] lane_load;

  assign flags  = '{is_load: is_load_op_i, is_store: is_store_op_i, is_byte: is_byte_op_i};
  assign mem_op = is_mem_op(valid_i, flags);

  // The lane steers live inputs while capturing a request, then the captured op for the response.
  assign lane_byte = (state == IDLE) ? is_byte_op_i : op_byte_q;
  assign lane_off  = (state == IDLE) ? addr_i[1:0]  : op_off_q;

  assign stall_o = ((state == IDLE) && mem_op) || (state == REQ) || (state == WAIT);

`ifdef MEM_ALIGN_CHECK_EN
  logic misaligned_op;
  assign misaligned_op = mem_op && !is_byte_op_i && (addr_i[1:0] != 2'b00);
`endif

  cl_mem_lane u_lane (
    .is_byte    (lane_byte),
    .offset     (lane_off),
    .store_data (store_data_i),
    .resp_data  (mem_resp_data_i),
    .be         (lane_be),
    .wdata      (lane_wdata),
    .load_data  (lane_load)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      op_load_q       <= 1'b0;
      op_byte_q       <= 1'b0;
      op_off_q        <= 2'b00;
      load_valid_o    <= 1'b0;
      load_data_o     <= 32'b0;
      mem_req_valid_o <= 1'b0;
      mem_we_o        <= 1'b0;
      mem_addr_o      <= '0;
      mem_wdata_o     <= 32'b0;
      mem_be_o        <= 4'b0;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned_o    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (mem_op) begin
            op_load_q   <= is_load_op_i;
            op_byte_q   <= is_byte_op_i;
            op_off_q    <= addr_i[1:0];
            mem_we_o    <= !is_load_op_i;
            mem_addr_o  <= {addr_i[ADDR_WIDTH-1:2], 2'b00};
            mem_be_o    <= lane_be;
            mem_wdata_o <= lane_wdata;
`ifdef MEM_ALIGN_CHECK_EN
            if (misaligned_op) begin
              misaligned_o <= 1'b1;
              state        <= DONE;
            end else begin
              mem_req_valid_o <= 1'b1;
              state           <= REQ;
            end
`else
            mem_req_valid_o <= 1'b1;
            state           <= REQ;
`endif
          end
        end
        REQ: begin
          if (mem_req_ready_i) begin
            mem_req_valid_o <= 1'b0;
            state           <= op_load_q ? WAIT : DONE;
          end
        end
        WAIT: begin
          if (mem_resp_valid_i) begin
            load_data_o  <= lane_load;
            load_valid_o <= 1'b1;
            state        <= DONE;
          end
        end
        default: begin
          load_valid_o <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
          misaligned_o <= 1'b0;
`endif
          state        <= IDLE;
        end
      endcase
    end
  end

  // Saturating performance counter of stalled cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cycles_o <= '0;
    end else if (stall_o && (stall_cycles_o != '1)) begin
      stall_cycles_o <= stall_cycles_o + STALL_CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_cl_mem_access.sv
// Directed self-checking bench for cl_mem_access; the misalignment case runs
// only when MEM_ALIGN_CHECK_EN is defined.
module tb_cl_mem_access;

  logic        clk;
  logic        reset;
  logic        valid_i;
  logic        is_load_op_i;
  logic        is_store_op_i;
  logic        is_byte_op_i;
  logic [31:0] addr_i;
  logic [31:0] store_data_i;
  logic        stall_o;
  logic        load_valid_o;
  logic [31:0] load_data_o;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic [3:0]  mem_be_o;
  logic        mem_resp_valid_i;
  logic [31:0] mem_resp_data_i;
  logic [31:0] stall_cycles_o;
`ifdef MEM_ALIGN_CHECK_EN
  logic        misaligned_o;
`endif

  int checkCount = 0;
  int errorCount = 0;
  int expStall   = 0;

  cl_mem_access dut (
    .clk              (clk),
    .reset            (reset),
    .valid_i          (valid_i),
    .is_load_op_i     (is_load_op_i),
    .is_store_op_i    (is_store_op_i),
    .is_byte_op_i     (is_byte_op_i),
    .addr_i           (addr_i),
    .store_data_i     (store_data_i),
    .stall_o          (stall_o),
    .load_valid_o     (load_valid_o),
    .load_data_o      (load_data_o),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_ready_i  (mem_req_ready_i),
    .mem_we_o         (mem_we_o),
    .mem_addr_o       (mem_addr_o),
    .mem_wdata_o      (mem_wdata_o),
    .mem_be_o         (mem_be_o),
    .mem_resp_valid_i (mem_resp_valid_i),
    .mem_resp_data_i  (mem_resp_data_i),
`ifdef MEM_ALIGN_CHECK_EN
    .misaligned_o     (misaligned_o),
`endif
    .stall_cycles_o   (stall_cycles_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic ld, input logic st, input logic byteOp,
                               input logic [31:0] addr, input logic [31:0] data);
    valid_i       = valid;
    is_load_op_i  = ld;
    is_store_op_i = st;
    is_byte_op_i  = byteOp;
    addr_i        = addr;
    store_data_i  = data;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b0;
    mem_resp_data_i  = 32'h0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    nextCycle();
    reset = 1'b0;
    #1;
    checkOutput("reset_stall", stall_o, 0);
    checkOutput("reset_req_valid", mem_req_valid_o, 0);
    checkOutput("reset_be", mem_be_o, 0);
    checkOutput("reset_load_valid", load_valid_o, 0);
    checkOutput("reset_stall_cycles", stall_cycles_o, 0);

    $display("[TB] SW word store");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'h100, 32'hA5A5_1234);
    checkOutput("sw_idle_stall", stall_o, 1);
    nextCycle();
    checkOutput("sw_req_valid", mem_req_valid_o, 1);
    checkOutput("sw_we", mem_we_o, 1);
    checkOutput("sw_be", mem_be_o, 4'b1111);
    checkOutput("sw_addr", mem_addr_o, 32'h100);
    checkOutput("sw_wdata", mem_wdata_o, 32'hA5A5_1234);
    checkOutput("sw_req_stall", stall_o, 1);
    mem_req_ready_i = 1'b1;
    nextCycle();
    expStall += 2;
    checkOutput("sw_done_stall", stall_o, 0);
    checkOutput("sw_done_req_valid", mem_req_valid_o, 0);
    checkOutput("sw_done_load_valid", load_valid_o, 0);
    checkOutput("sw_stall_cycles", stall_cycles_o, expStall);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    $display("[TB] SB byte store to lane 3");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 32'h103, 32'h0000_00EE);
    nextCycle();
    checkOutput("sb_be", mem_be_o, 4'b1000);
    checkOutput("sb_wdata", mem_wdata_o, 32'hEEEE_EEEE);
    checkOutput("sb_addr", mem_addr_o, 32'h100);
    checkOutput("sb_we", mem_we_o, 1);
    nextCycle();
    expStall += 2;
    checkOutput("sb_done_load_valid", load_valid_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    $display("[TB] LBU with 3-cycle response latency");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h202, 32'h0);
    nextCycle();
    checkOutput("lbu_we", mem_we_o, 0);
    checkOutput("lbu_be", mem_be_o, 4'b0100);
    checkOutput("lbu_addr", mem_addr_o, 32'h200);
    nextCycle();
    checkOutput("lbu_wait_req_valid", mem_req_valid_o, 0);
    checkOutput("lbu_wait1_stall", stall_o, 1);
    mem_req_ready_i = 1'b0;
    nextCycle();
    checkOutput("lbu_wait2_stall", stall_o, 1);
    checkOutput("lbu_wait2_load_valid", load_valid_o, 0);
    nextCycle();
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'h1122_3344;
    #1;
    checkOutput("lbu_wait3_stall", stall_o, 1);
    nextCycle();
    mem_resp_valid_i = 1'b0;
    expStall += 5;
    checkOutput("lbu_load_valid", load_valid_o, 1);
    checkOutput("lbu_load_data", load_data_o, 32'h0000_0022);
    checkOutput("lbu_done_stall", stall_o, 0);
    checkOutput("lbu_stall_cycles", stall_cycles_o, expStall);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("lbu_pulse_end", load_valid_o, 0);

    $display("[TB] stray response in IDLE");
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'hFFFF_FFFF;
    nextCycle();
    mem_resp_valid_i = 1'b0;
    checkOutput("idle_resp_load_valid", load_valid_o, 0);
    checkOutput("idle_resp_load_data", load_data_o, 32'h0000_0022);

    $display("[TB] LW with ready held low for 5 cycles");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h404, 32'h0);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("lw_hold_req_valid_%0d", i), mem_req_valid_o, 1);
      checkOutput($sformatf("lw_hold_addr_%0d", i), mem_addr_o, 32'h404);
      checkOutput($sformatf("lw_hold_be_%0d", i), mem_be_o, 4'b1111);
      checkOutput($sformatf("lw_hold_stall_%0d", i), stall_o, 1);
      checkOutput($sformatf("lw_hold_count_%0d", i), stall_cycles_o, expStall + 1 + i);
      nextCycle();
    end
    mem_req_ready_i = 1'b1;
    nextCycle();
    mem_req_ready_i  = 1'b0;
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'hDEAD_BEEF;
    nextCycle();
    mem_resp_valid_i = 1'b0;
    expStall += 8;
    checkOutput("lw_load_valid", load_valid_o, 1);
    checkOutput("lw_load_data", load_data_o, 32'hDEAD_BEEF);
    checkOutput("lw_stall_cycles", stall_cycles_o, expStall);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();

    $display("[TB] reset while waiting, then stray response");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h500, 32'h0);
    nextCycle();
    mem_req_ready_i = 1'b1;
    nextCycle();
    mem_req_ready_i = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    checkOutput("rst_pre_stall", stall_o, 1);
    reset = 1'b1;
    nextCycle();
    reset = 1'b0;
    checkOutput("rst_stall", stall_o, 0);
    checkOutput("rst_req_valid", mem_req_valid_o, 0);
    checkOutput("rst_addr", mem_addr_o, 0);
    checkOutput("rst_load_data", load_data_o, 0);
    checkOutput("rst_stall_cycles", stall_cycles_o, 0);
    mem_resp_valid_i = 1'b1;
    mem_resp_data_i  = 32'h5555_AAAA;
    nextCycle();
    mem_resp_valid_i = 1'b0;
    checkOutput("rst_stray_load_valid", load_valid_o, 0);
    checkOutput("rst_stray_load_data", load_data_o, 0);
    checkOutput("rst_stray_stall", stall_o, 0);
    nextCycle();

`ifdef MEM_ALIGN_CHECK_EN
    $display("[TB] misaligned LW");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'h301, 32'h0);
    checkOutput("mis_idle_stall", stall_o, 1);
    nextCycle();
    checkOutput("mis_flag", misaligned_o, 1);
    checkOutput("mis_req_valid", mem_req_valid_o, 0);
    checkOutput("mis_load_valid", load_valid_o, 0);
    checkOutput("mis_done_stall", stall_o, 0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    nextCycle();
    checkOutput("mis_flag_clear", misaligned_o, 0);
    checkOutput("mis_req_valid_after", mem_req_valid_o, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
